// File: rtl/ex_div_unit.sv
// ex_div_unit -- iterative 32-bit integer divider for the EX stage.
//
// Runs a restoring radix-2 divide on operand magnitudes and produces one
// quotient bit per cycle, MSB first. The quotient and remainder signs are
// applied when the result is registered. Divide-by-zero and signed overflow
// can optionally bypass the iteration when FAST_SPECIAL is set.
//
// The opcode values default to this file's own choice of encoding. Override
// them to match the ALU_* codes in sys_defs.vh when integrating.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   req_vld   EX stage presents a divide request
//   req_rdy   unit is idle and can accept a request
//   req_func  ALU_DIV / ALU_DIVU / ALU_REM / ALU_REMU
//   req_opa   dividend
//   req_opb   divisor
//   flush     abort any operation in flight
//   rsp_vld   result available (state DONE)
//   rsp_rdy   consumer takes the result
//   rsp_res   quotient or remainder
//   busy      unit is not idle
module ex_div_unit #(
  parameter bit         FAST_SPECIAL = 1'b1,
  parameter logic [4:0] ALU_DIV      = 5'h0c,
  parameter logic [4:0] ALU_DIVU     = 5'h0d,
  parameter logic [4:0] ALU_REM      = 5'h0e,
  parameter logic [4:0] ALU_REMU     = 5'h0f
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [4:0]  req_func,
  input  logic [31:0] req_opa,
  input  logic [31:0] req_opb,
  input  logic        flush,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_res,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [4:0]  func_q;
  logic [31:0] quo_q;      // holds the dividend and shifts in quotient bits
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic        q_sign_q;
  logic        r_sign_q;
  logic        div_zero_q;

  // Request decode, operand magnitudes and the fast-path special results.
  logic        req_is_div;
  logic        req_signed;
  logic        req_quot;
  logic        req_zero;
  logic        req_ovf;
  logic        req_special;
  logic        accept;
  logic [31:0] opa_mag;
  logic [31:0] opb_mag;
  logic [31:0] fast_res;

  always_comb begin
    req_is_div  = (req_func == ALU_DIV) || (req_func == ALU_DIVU) ||
                  (req_func == ALU_REM) || (req_func == ALU_REMU);
    req_signed  = (req_func == ALU_DIV) || (req_func == ALU_REM);
    req_quot    = (req_func == ALU_DIV) || (req_func == ALU_DIVU);
    opa_mag     = (req_signed && req_opa[31]) ? (~req_opa + 32'd1) : req_opa;
    opb_mag     = (req_signed && req_opb[31]) ? (~req_opb + 32'd1) : req_opb;
    req_zero    = (req_opb == 32'd0);
    req_ovf     = req_signed && (req_opa == 32'h8000_0000) &&
                  (req_opb == 32'hffff_ffff);
    req_special = req_zero || req_ovf;
    if (req_zero) begin
      fast_res = req_quot ? 32'hffff_ffff : req_opa;
    end else begin
      fast_res = req_quot ? 32'h8000_0000 : 32'd0;
    end
    accept = req_vld && (state == IDLE) && !flush && req_is_div;
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. The partial remainder
  // is always below the divisor, so the 33-bit shifted value cannot
  // overflow, and the kept remainder always fits in 32 bits.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] final_res;

  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = (shifted >= {1'b0, dvs_q});
    rem_next = fits ? diff[31:0] : shifted[31:0];
    quo_next = {quo_q[30:0], fits};
    if ((func_q == ALU_DIV) || (func_q == ALU_DIVU)) begin
      // A zero divisor iterates to all ones, but the signed sign
      // correction would spoil it, so the result is forced.
      if (div_zero_q) final_res = 32'hffff_ffff;
      else            final_res = q_sign_q ? (~quo_next + 32'd1) : quo_next;
    end else begin
      final_res = r_sign_q ? (~rem_next + 32'd1) : rem_next;
    end
  end

  // Control FSM and datapath registers. Flush wins over everything else.
  // rsp_res is only written on entry to DONE, so it holds its value
  // everywhere else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      func_q     <= 5'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
      rem_q      <= 32'd0;
      q_sign_q   <= 1'b0;
      r_sign_q   <= 1'b0;
      div_zero_q <= 1'b0;
      rsp_res    <= 32'd0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            func_q     <= req_func;
            quo_q      <= opa_mag;
            dvs_q      <= opb_mag;
            rem_q      <= 32'd0;
            q_sign_q   <= req_signed & (req_opa[31] ^ req_opb[31]);
            r_sign_q   <= req_signed & req_opa[31];
            div_zero_q <= req_zero;
            cnt        <= 5'd31;
            if (FAST_SPECIAL && req_special) begin
              rsp_res <= fast_res;
              state   <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt == 5'd0) begin
            rsp_res <= final_res;
            state   <= DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE: begin
          if (rsp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_rdy = (state == IDLE);
  assign rsp_vld = (state == DONE);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit -- self-checking bench for ex_div_unit.
//
// Two instances share the request inputs: one with FAST_SPECIAL=1 and one
// with FAST_SPECIAL=0. Every transaction starts with a flush so both units
// begin from IDLE, then the outputs of the selected instance are checked
// against an arithmetic reference model.
module tb_ex_div_unit;

  localparam logic [4:0] F_DIV  = 5'h0c;
  localparam logic [4:0] F_DIVU = 5'h0d;
  localparam logic [4:0] F_REM  = 5'h0e;
  localparam logic [4:0] F_REMU = 5'h0f;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic [4:0]  req_func;
  logic [31:0] req_opa;
  logic [31:0] req_opb;
  logic        flush;
  logic        rsp_rdy;

  logic        f_req_rdy, f_rsp_vld, f_busy;
  logic [31:0] f_rsp_res;
  logic        s_req_rdy, s_rsp_vld, s_busy;
  logic [31:0] s_rsp_res;

  int checks = 0;
  int errors = 0;

  // 0 selects the fast instance, 1 the slow one.
  bit          sel = 1'b0;
  logic        m_req_rdy, m_rsp_vld, m_busy;
  logic [31:0] m_rsp_res;

  always_comb begin
    m_req_rdy = sel ? s_req_rdy : f_req_rdy;
    m_rsp_vld = sel ? s_rsp_vld : f_rsp_vld;
    m_busy    = sel ? s_busy    : f_busy;
    m_rsp_res = sel ? s_rsp_res : f_rsp_res;
  end

  ex_div_unit #(.FAST_SPECIAL(1'b1), .ALU_DIV(F_DIV), .ALU_DIVU(F_DIVU),
                .ALU_REM(F_REM), .ALU_REMU(F_REMU)) dut_fast (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(f_req_rdy),
    .req_func(req_func), .req_opa(req_opa), .req_opb(req_opb),
    .flush(flush), .rsp_vld(f_rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_res(f_rsp_res), .busy(f_busy)
  );

  ex_div_unit #(.FAST_SPECIAL(1'b0), .ALU_DIV(F_DIV), .ALU_DIVU(F_DIVU),
                .ALU_REM(F_REM), .ALU_REMU(F_REMU)) dut_slow (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(s_req_rdy),
    .req_func(req_func), .req_opa(req_opa), .req_opb(req_opb),
    .flush(flush), .rsp_vld(s_rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_res(s_rsp_res), .busy(s_busy)
  );

  always #5 clk = ~clk;

  // Reference result straight from the arithmetic rules.
  function automatic logic [31:0] model_res(input logic [4:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic sgn;
    logic quot;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sgn  = (f == F_DIV) || (f == F_REM);
    quot = (f == F_DIV) || (f == F_DIVU);
    sa   = a;
    sb   = b;
    if (b == 32'd0) return quot ? 32'hffff_ffff : a;
    if (sgn && a == 32'h8000_0000 && b == 32'hffff_ffff)
      return quot ? 32'h8000_0000 : 32'd0;
    if (sgn) begin
      if (quot) return sa / sb;
      return sa % sb;
    end
    if (quot) return a / b;
    return a % b;
  endfunction

  // Edges from (and including) the accepting edge until rsp_vld is seen.
  function automatic int model_lat(input logic [4:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input bit fast);
    logic sgn;
    logic special;
    sgn     = (f == F_DIV) || (f == F_REM);
    special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hffff_ffff);
    return (fast && special) ? 1 : 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Flush both units, then present one request for exactly one edge.
  task automatic start_op(input logic [4:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("req_rdy_before_accept", {31'd0, m_req_rdy}, 32'd1);
    req_vld  = 1'b1;
    req_func = f;
    req_opa  = a;
    req_opb  = b;
    tick();
    req_vld = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (m_rsp_vld !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [4:0] f,
                                input logic [31:0] a, input logic [31:0] b);
    int lat;
    start_op(f, a, b);
    wait_rsp(lat);
    check({tag, "_lat"}, lat, model_lat(f, a, b, !sel));
    check({tag, "_res"}, m_rsp_res, model_res(f, a, b));
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    check({tag, "_idle"}, {31'd0, m_busy}, 32'd0);
  endtask

  function automatic logic [31:0] gen_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'h8000_0000;
      3:       return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    logic [31:0] held;
    logic [4:0] funcs [4];
    funcs = '{F_DIV, F_DIVU, F_REM, F_REMU};

    rst = 1'b0; req_vld = 1'b0; req_func = 5'd0; req_opa = 32'd0;
    req_opb = 32'd0; flush = 1'b0; rsp_rdy = 1'b0;

    // Reset values, and no acceptance while reset is held.
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #0;
      check("rst_req_rdy", {31'd0, m_req_rdy}, 32'd1);
      check("rst_busy",    {31'd0, m_busy},    32'd0);
      check("rst_rsp_vld", {31'd0, m_rsp_vld}, 32'd0);
      check("rst_rsp_res", m_rsp_res,          32'd0);
    end
    sel = 1'b0;
    req_vld = 1'b1; req_func = F_DIVU; req_opa = 32'd100; req_opb = 32'd7;
    repeat (3) tick();
    check("rst_no_accept", {31'd0, f_busy | s_busy}, 32'd0);
    req_vld = 1'b0;
    rst = 1'b1;
    tick();

    // Unknown opcode is ignored.
    req_vld = 1'b1; req_func = 5'h1f;
    repeat (3) tick();
    check("bad_func_ignored", {31'd0, f_busy | s_busy}, 32'd0);
    req_vld = 1'b0;

    // Flush beats acceptance in the same cycle.
    req_vld = 1'b1; req_func = F_DIVU; flush = 1'b1;
    tick();
    check("flush_beats_accept", {31'd0, f_busy | s_busy}, 32'd0);
    req_vld = 1'b0; flush = 1'b0;

    // Directed cases on the fast instance, then the slow one.
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      apply_stimulus("divu_100_7", F_DIVU, 32'd100, 32'd7);
      apply_stimulus("remu_100_7", F_REMU, 32'd100, 32'd7);
      apply_stimulus("div_m7_2",   F_DIV,  32'hffff_fff9, 32'd2);
      apply_stimulus("rem_m7_2",   F_REM,  32'hffff_fff9, 32'd2);
      apply_stimulus("div_7_m2",   F_DIV,  32'd7, 32'hffff_fffe);
      apply_stimulus("rem_7_m2",   F_REM,  32'd7, 32'hffff_fffe);
      apply_stimulus("divu_by0",   F_DIVU, 32'h1234_5678, 32'd0);
      apply_stimulus("div_by0",    F_DIV,  32'h8765_4321, 32'd0);
      apply_stimulus("rem_by0",    F_REM,  32'h1234_5678, 32'd0);
      apply_stimulus("rem_by0_neg", F_REM, 32'hf234_5678, 32'd0);
      apply_stimulus("div_ovf",    F_DIV,  32'h8000_0000, 32'hffff_ffff);
      apply_stimulus("rem_ovf",    F_REM,  32'h8000_0000, 32'hffff_ffff);
    end

    // Backpressure: result held in DONE while rsp_rdy stays low, and a new
    // request presented meanwhile is not taken.
    sel = 1'b0;
    start_op(F_DIVU, 32'd1000, 32'd10);
    wait_rsp(seen);
    check("bp_lat", seen, 33);
    held = model_res(F_DIVU, 32'd1000, 32'd10);
    req_vld = 1'b1; req_func = F_DIVU; req_opa = 32'd50; req_opb = 32'd5;
    for (int i = 0; i < 5; i++) begin
      check("bp_vld",     {31'd0, m_rsp_vld}, 32'd1);
      check("bp_res",     m_rsp_res,          held);
      check("bp_req_rdy", {31'd0, m_req_rdy}, 32'd0);
      check("bp_busy",    {31'd0, m_busy},    32'd1);
      tick();
    end
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    check("bp_exit_req_rdy", {31'd0, m_req_rdy}, 32'd1);
    check("bp_exit_vld",     {31'd0, m_rsp_vld}, 32'd0);
    check("bp_exit_res",     m_rsp_res,          held);

    // Flush mid-CALC: back to IDLE and no response ever appears.
    start_op(F_DIVU, 32'hffff_ffff, 32'd3);
    repeat (10) tick();
    check("calc_busy", {31'd0, m_busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", {31'd0, m_busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_rsp_vld === 1'b1) seen++;
      tick();
    end
    check("flush_no_rsp", seen, 0);
    apply_stimulus("after_flush", F_DIVU, 32'd9, 32'd3);

    // Reset mid-CALC: outputs change without waiting for a clock edge.
    start_op(F_DIV, 32'hffff_ff00, 32'd7);
    repeat (10) tick();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy",    {31'd0, m_busy},    32'd0);
    check("midrst_rsp_vld", {31'd0, m_rsp_vld}, 32'd0);
    check("midrst_rsp_res", m_rsp_res,          32'd0);
    check("midrst_req_rdy", {31'd0, m_req_rdy}, 32'd1);
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_rsp_vld === 1'b1) seen++;
      tick();
    end
    check("midrst_no_rsp", seen, 0);
    apply_stimulus("after_rst", F_DIVU, 32'd9, 32'd3);

    // Randomized operations against the reference model on both instances.
    for (int i = 0; i < 48; i++) begin
      sel = (i % 4 == 3);
      apply_stimulus("rand", funcs[$urandom_range(0, 3)], gen_opnd(), gen_opnd());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
